// File: rtl/password_store_responder.sv
`default_nettype none
// ============================================================================
// Module   : password_store_responder
// Purpose  : Password slot memory with default fill after reset, 2-cycle reads,
//            and checked password-change writes. Build option PW_PARITY_EN
//            adds an even-parity bit per slot and drives par_err.
// Revision : 1.0  initial release
// ============================================================================
module password_store_responder #(
  parameter int              DEPTH      = 16,
  parameter int              AW         = 4,
  parameter int              DW         = 16,
  parameter logic [DW-1:0]   DEFAULT_PW = 16'h1234
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [15:0]   addr,
  input  logic          wren,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          ready,
  output logic          addr_err,
  output logic          wr_ack,
  output logic          wr_rej,
  output logic          par_err
);

`ifdef PW_PARITY_EN
  localparam int c_mem_w = DW + 1;
`else
  localparam int c_mem_w = DW;
`endif
  localparam logic [AW-1:0] c_last_idx = AW'(DEPTH - 1);

  typedef enum logic [0:0] {
    S_INIT = 1'b0,
    S_IDLE = 1'b1
  } state_t;

  state_t               r_state;
  logic [AW-1:0]        r_fill_idx;
  logic [AW-1:0]        r_addr_q;
  logic                 r_oor_q;
  logic [c_mem_w-1:0]   r_mem [DEPTH];

  logic                 w_oor;
  logic                 w_wr_ok;
  logic [c_mem_w-1:0]   w_fill_word;
  logic [c_mem_w-1:0]   w_wr_word;
  logic [c_mem_w-1:0]   w_rd_word;

  // Upper address bits only take part in the range check.
  assign w_oor     = |addr[15:AW];
  assign w_wr_ok   = (r_state == S_IDLE) && wren && !w_oor && (wdata != '0);
  assign w_rd_word = r_mem[r_addr_q];

`ifdef PW_PARITY_EN
  assign w_fill_word = {^DEFAULT_PW, DEFAULT_PW};
  assign w_wr_word   = {^wdata, wdata};
`else
  assign w_fill_word = DEFAULT_PW;
  assign w_wr_word   = wdata;
`endif

  // Storage is deliberately not reset; the init fill overwrites every slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (r_state == S_INIT) begin
        r_mem[r_fill_idx] <= w_fill_word;
      end else if (w_wr_ok) begin
        r_mem[addr[AW-1:0]] <= w_wr_word;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_INIT;
      r_fill_idx <= '0;
      r_addr_q   <= '0;
      r_oor_q    <= 1'b0;
      rdata      <= '0;
      ready      <= 1'b0;
      addr_err   <= 1'b0;
      wr_ack     <= 1'b0;
      wr_rej     <= 1'b0;
    end else begin
      case (r_state)
        S_INIT: begin
          r_fill_idx <= r_fill_idx + 1'b1;
          rdata      <= '0;
          addr_err   <= 1'b0;
          wr_ack     <= 1'b0;
          wr_rej     <= wren;
          if (r_fill_idx == c_last_idx) begin
            r_state <= S_IDLE;
            ready   <= 1'b1;
          end
        end
        S_IDLE: begin
          r_addr_q <= addr[AW-1:0];
          r_oor_q  <= w_oor;
          // Array read samples the pre-edge contents: same-edge write returns old data.
          rdata    <= r_oor_q ? '0 : w_rd_word[DW-1:0];
          addr_err <= r_oor_q | (wren & w_oor);
          wr_ack   <= w_wr_ok;
          wr_rej   <= wren & !w_wr_ok;
        end
        default: begin
          r_state <= S_INIT;
        end
      endcase
    end
  end

`ifdef PW_PARITY_EN
  logic r_par_err;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_par_err <= 1'b0;
    end else if (r_state == S_IDLE) begin
      r_par_err <= !r_oor_q && (^w_rd_word);
    end else begin
      r_par_err <= 1'b0;
    end
  end

  assign par_err = r_par_err;
`else
  assign par_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_password_store_responder.sv
`default_nettype none
// Testbench for password_store_responder: model memory plus a queue of expected
// read results, popped two edges after each address is presented.
module tb_password_store_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic        wren;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        ready;
  logic        addr_err;
  logic        wr_ack;
  logic        wr_rej;
  logic        par_err;

  password_store_responder dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .wren     (wren),
    .wdata    (wdata),
    .rdata    (rdata),
    .ready    (ready),
    .addr_err (addr_err),
    .wr_ack   (wr_ack),
    .wr_rej   (wr_rej),
    .par_err  (par_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic        err;
    logic        par;
  } rd_exp_t;

  rd_exp_t     rd_q[$];
  logic [15:0] m_mem [16];
  logic        m_bad [16];
  int          m_cnt;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_mem[i] = 16'h1234;
      m_bad[i] = 1'b0;
    end
    m_cnt = 0;
    rd_q.delete();
  endtask

  // One clock of stimulus with full response checking.
  task automatic cycle(input logic [15:0] a, input logic we, input logic [15:0] wd);
    logic    idle, oor, ok, exp_ack, exp_rej, exp_werr;
    rd_exp_t e;
    idle     = (m_cnt >= 16);
    oor      = (a >= 16'd16);
    ok       = idle && we && !oor && (wd != 16'h0);
    exp_ack  = ok;
    exp_rej  = we && !ok;
    exp_werr = idle && we && oor;
    if (ok) begin
      m_mem[a[3:0]] = wd;
      m_bad[a[3:0]] = 1'b0;
    end
    addr = a; wren = we; wdata = wd;
    @(posedge clk); #1;
    if (!idle) m_cnt++;

    n_vec++;
    if (wr_ack !== exp_ack) begin
      n_err++; $display("FAIL wr_ack addr=%h: got %b want %b", a, wr_ack, exp_ack);
    end
    n_vec++;
    if (wr_rej !== exp_rej) begin
      n_err++; $display("FAIL wr_rej addr=%h: got %b want %b", a, wr_rej, exp_rej);
    end
    n_vec++;
    if (ready !== (m_cnt >= 16)) begin
      n_err++; $display("FAIL ready cnt=%0d: got %b want %b", m_cnt, ready, m_cnt >= 16);
    end

    if (idle) begin
      if (rd_q.size() > 0) begin
        e = rd_q.pop_front();
        n_vec++;
        if (rdata !== e.data) begin
          n_err++; $display("FAIL rdata: got %h want %h", rdata, e.data);
        end
        n_vec++;
        if (addr_err !== (e.err | exp_werr)) begin
          n_err++; $display("FAIL addr_err: got %b want %b", addr_err, e.err | exp_werr);
        end
        n_vec++;
        if (par_err !== e.par) begin
          n_err++; $display("FAIL par_err: got %b want %b", par_err, e.par);
        end
      end else begin
        n_vec++;
        if (addr_err !== exp_werr) begin
          n_err++; $display("FAIL addr_err_first: got %b want %b", addr_err, exp_werr);
        end
      end
      e.data = oor ? 16'h0 : m_mem[a[3:0]];
      e.err  = oor;
      e.par  = oor ? 1'b0 : m_bad[a[3:0]];
      rd_q.push_back(e);
    end else begin
      n_vec++;
      if (rdata !== 16'h0 || addr_err !== 1'b0 || par_err !== 1'b0) begin
        n_err++;
        $display("FAIL init_outputs: got rdata=%h addr_err=%b par_err=%b want 0/0/0",
                 rdata, addr_err, par_err);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; addr = 16'h0; wren = 1'b1; wdata = 16'h5555;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({rdata, ready, addr_err, wr_ack, wr_rej, par_err} !== 21'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got rdata=%h rdy=%b ae=%b ack=%b rej=%b pe=%b want all 0",
               rdata, ready, addr_err, wr_ack, wr_rej, par_err);
    end
    model_reset();
    rst = 1'b1; wren = 1'b0;
  endtask

  task automatic test_init_fill();
    for (int i = 0; i < 16; i++) cycle(16'h0, 1'b0, 16'h0);
    for (int i = 0; i < 16; i++) cycle(16'(i), 1'b0, 16'h0);
    repeat (2) cycle(16'h0, 1'b0, 16'h0);
  endtask

  task automatic test_write();
    cycle(16'd3, 1'b1, 16'hBEEF);
    cycle(16'd3, 1'b0, 16'h0);
    cycle(16'd4, 1'b0, 16'h0);
    repeat (2) cycle(16'd0, 1'b0, 16'h0);
  endtask

  task automatic test_zero_write();
    cycle(16'd5, 1'b1, 16'h0);
    cycle(16'd5, 1'b0, 16'h0);
    repeat (2) cycle(16'd0, 1'b0, 16'h0);
  endtask

  task automatic test_out_of_range();
    cycle(16'h0020, 1'b0, 16'h0);
    cycle(16'd0, 1'b0, 16'h0);
    cycle(16'h0020, 1'b1, 16'h7777);
    cycle(16'd0, 1'b0, 16'h0);
    cycle(16'hFFF0, 1'b1, 16'h0);
    repeat (2) cycle(16'd0, 1'b0, 16'h0);
  endtask

  task automatic test_back_to_back();
    cycle(16'd6, 1'b1, 16'hAAAA);
    cycle(16'd6, 1'b1, 16'h5555);   // read of slot 6 lands on this write edge: old data
    cycle(16'd6, 1'b1, 16'h5555);
    cycle(16'd7, 1'b1, 16'h0F0F);
    cycle(16'd7, 1'b0, 16'h0);
    repeat (2) cycle(16'd6, 1'b0, 16'h0);
  endtask

  task automatic test_reset_mid_init();
    test_reset();
    for (int i = 0; i < 7; i++) cycle(16'd1, 1'b1, 16'h4321);
    test_reset();
    for (int i = 0; i < 16; i++) cycle(16'(i), 1'b1, 16'h9999);
    for (int i = 0; i < 16; i++) cycle(16'(i), 1'b0, 16'h0);
    repeat (2) cycle(16'd0, 1'b0, 16'h0);
  endtask

  task automatic test_random();
    logic [15:0] a, d;
    for (int i = 0; i < 60; i++) begin
      a = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(16, 65535))
                                      : 16'($urandom_range(0, 15));
      d = ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom);
      cycle(a, 1'($urandom_range(0, 1)), d);
    end
    repeat (2) cycle(16'd0, 1'b0, 16'h0);
  endtask

`ifdef PW_PARITY_EN
  task automatic test_parity();
    dut.r_mem[2][0] = ~dut.r_mem[2][0];
    m_mem[2][0]     = ~m_mem[2][0];
    m_bad[2]        = 1'b1;
    cycle(16'd2, 1'b0, 16'h0);
    cycle(16'd1, 1'b0, 16'h0);
    cycle(16'd2, 1'b0, 16'h0);
    repeat (2) cycle(16'd0, 1'b0, 16'h0);
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_init_fill();
    test_write();
    test_zero_write();
    test_out_of_range();
    test_back_to_back();
`ifdef PW_PARITY_EN
    test_parity();
`endif
    test_random();
    test_reset_mid_init();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
